// File: rtl/result_trace_buffer.sv
// result_trace_buffer
//
// Watches the processor's 32-bit result bus and logs every new value, tagged with a
// free-running cycle stamp, into a small circular FIFO. A consumer drains the FIFO
// through a valid/ready handshake. Entries that arrive while the FIFO is full and no
// pop is happening are dropped and recorded in a sticky flag and a saturating counter.
//
// Ports:
//   clk         - single clock, rising edge
//   reset       - synchronous active-high reset, clears all state
//   out_value   - result bus, sampled every cycle
//   capture_en  - enables logging; when low the change tracker is frozen
//   clear       - synchronous flush of FIFO, tracker and drop status (stamp keeps counting)
//   rd_valid    - head entry available
//   rd_ready    - consumer accepts head entry
//   rd_value    - head entry value
//   rd_stamp    - head entry timestamp
//   count       - FIFO occupancy, 0..DEPTH
//   overflow    - sticky, set once any entry was dropped
//   drop_count  - number of dropped entries, saturating
//   stamp_now   - free-running cycle counter

module result_trace_buffer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned STAMP_W = 16,
  parameter int unsigned DROP_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            out_value,
  input  logic                   capture_en,
  input  logic                   clear,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [31:0]            rd_value,
  output logic [STAMP_W-1:0]     rd_stamp,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  output logic [STAMP_W-1:0]     stamp_now
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Pointers carry one extra wrap bit so equal pointers always mean empty.
  typedef logic [AW:0] ptr_t;

  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [31:0]        prev_value_q, prev_value_d;
  logic               prev_valid_q, prev_valid_d;
  ptr_t               wr_ptr_q, wr_ptr_d;
  ptr_t               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               rd_valid_q, rd_valid_d;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [31:0]        mem_value_q [DEPTH];
  logic [31:0]        mem_value_d [DEPTH];
  logic [STAMP_W-1:0] mem_stamp_q [DEPTH];
  logic [STAMP_W-1:0] mem_stamp_d [DEPTH];

  logic changed;
  logic log_en;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Event decode
  always_comb begin
    changed = !prev_valid_q || (out_value != prev_value_q);
    log_en  = capture_en && !clear && changed;
    full    = (count_q == CW'(DEPTH));
    pop     = rd_valid_q && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push    = log_en && (!full || pop);
    drop    = log_en && full && !pop;
  end

  // Next-state logic
  always_comb begin
    stamp_d      = stamp_q + STAMP_W'(1);

    prev_value_d = prev_value_q;
    prev_valid_d = prev_valid_q;
    if (capture_en) begin
      prev_value_d = out_value;
      prev_valid_d = 1'b1;
    end
    // Clearing forces the next enabled sample to be logged.
    if (clear) begin
      prev_valid_d = 1'b0;
    end

    mem_value_d = mem_value_q;
    mem_stamp_d = mem_stamp_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      mem_value_d[wr_ptr_q[AW-1:0]] = out_value;
      mem_stamp_d[wr_ptr_q[AW-1:0]] = stamp_q;
      wr_ptr_d                      = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end

    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end

    rd_valid_d = (wr_ptr_d != rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_q      <= '0;
      prev_value_q <= '0;
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_value_q[i] <= '0;
        mem_stamp_q[i] <= '0;
      end
    end else begin
      stamp_q      <= stamp_d;
      prev_value_q <= prev_value_d;
      prev_valid_q <= prev_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_valid_q   <= rd_valid_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
      mem_value_q  <= mem_value_d;
      mem_stamp_q  <= mem_stamp_d;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_value   = mem_value_q[rd_ptr_q[AW-1:0]];
  assign rd_stamp   = mem_stamp_q[rd_ptr_q[AW-1:0]];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign stamp_now  = stamp_q;

endmodule

// File: tb/tb_result_trace_buffer.sv
module tb_result_trace_buffer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned STAMP_W = 4;
  localparam int unsigned DROP_W  = 8;

  logic                   clk;
  logic                   reset;
  logic [31:0]            out_value;
  logic                   capture_en;
  logic                   clear;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [31:0]            rd_value;
  logic [STAMP_W-1:0]     rd_stamp;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic [DROP_W-1:0]      drop_count;
  logic [STAMP_W-1:0]     stamp_now;

  typedef struct packed {
    logic [STAMP_W-1:0] stamp;
    logic [31:0]        value;
  } entry_t;

  entry_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  // Reference cycle counter: 0 while in reset, +1 per cycle, wraps at 2^STAMP_W.
  logic [STAMP_W-1:0] exp_stamp;

  result_trace_buffer #(
    .DEPTH  (DEPTH),
    .STAMP_W(STAMP_W),
    .DROP_W (DROP_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .out_value (out_value),
    .capture_en(capture_en),
    .clear     (clear),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_value  (rd_value),
    .rd_stamp  (rd_stamp),
    .count     (count),
    .overflow  (overflow),
    .drop_count(drop_count),
    .stamp_now (stamp_now)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (reset) exp_stamp <= '0;
    else       exp_stamp <= exp_stamp + 4'd1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    capture_en = 1'b0;
    clear      = 1'b0;
    rd_ready   = 1'b0;
    out_value  = '0;
    exp_q.delete();
    cyc();
    cyc();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_stamp_now", stamp_now, 0);
    check("rst_rd_value", rd_value, 0);
    check("rst_rd_stamp", rd_stamp, 0);
    reset = 1'b0;
  endtask

  // Drive one sample for one cycle; 'logged' says whether it must land in the FIFO.
  task automatic drive(input logic [31:0] v, input bit logged);
    entry_t e;
    out_value = v;
    if (logged) begin
      e.stamp = exp_stamp;
      e.value = v;
      exp_q.push_back(e);
    end
    cyc();
  endtask

  task automatic check_head(input string tag);
    entry_t e;
    e = exp_q.pop_front();
    check({tag, "_value"}, rd_value, e.value);
    check({tag, "_stamp"}, rd_stamp, e.stamp);
  endtask

  // Pop everything expected, holding out_value so nothing new is logged.
  task automatic drain(input string tag);
    int budget;
    budget   = 4 * DEPTH;
    rd_ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      if (rd_valid) check_head(tag);
      cyc();
      budget--;
    end
    check({tag, "_left"}, exp_q.size(), 0);
    rd_ready = 1'b0;
    check({tag, "_empty_valid"}, rd_valid, 0);
    check({tag, "_empty_count"}, count, 0);
  endtask

  initial begin
    logic [STAMP_W-1:0] s;
    logic [STAMP_W-1:0] s_next;

    // First-sample capture and duplicates
    do_reset();
    capture_en = 1'b1;
    drive(32'h5, 1'b1);
    for (int i = 0; i < 4; i++) drive(32'h5, 1'b0);
    check("dup_count", count, 1);
    check("dup_valid", rd_valid, 1);
    drain("dup");

    // Change sequence and drain
    do_reset();
    capture_en = 1'b1;
    drive(32'hA, 1'b1);
    check("seq_latency_valid", rd_valid, 1);
    check("seq_latency_count", count, 1);
    drive(32'hA, 1'b0);
    drive(32'hB, 1'b1);
    drive(32'hC, 1'b1);
    drive(32'hC, 1'b0);
    drive(32'hA, 1'b1);
    check("seq_count", count, 4);
    drain("seq");

    // Overflow
    do_reset();
    capture_en = 1'b1;
    for (int v = 1; v <= 6; v++) drive(32'(v), v <= 4);
    check("ovf_count", count, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_drop_count", drop_count, 2);
    drain("ovf");
    check("ovf_flag_sticky", overflow, 1);

    // Full push+pop
    do_reset();
    capture_en = 1'b1;
    for (int v = 1; v <= 4; v++) drive(32'(v), 1'b1);
    check("fpp_fill_count", count, 4);
    for (int i = 0; i < 8; i++) begin
      rd_ready = 1'b1;
      check("fpp_valid", rd_valid, 1);
      check_head("fpp");
      drive(32'h100 + 32'(i), 1'b1);
      check("fpp_count", count, 4);
      check("fpp_drop_count", drop_count, 0);
    end
    drain("fpp_tail");

    // Clear mid-operation
    do_reset();
    capture_en = 1'b1;
    for (int v = 1; v <= 6; v++) drive(32'(v), v <= 4);
    rd_ready = 1'b1;
    check("clr_pop_valid", rd_valid, 1);
    check_head("clr_pop");
    cyc();
    rd_ready = 1'b0;
    check("clr_pre_count", count, 3);
    check("clr_pre_overflow", overflow, 1);
    s         = stamp_now;
    clear     = 1'b1;
    rd_ready  = 1'b1;
    out_value = 32'h77;
    cyc();
    clear    = 1'b0;
    rd_ready = 1'b0;
    exp_q.delete();
    s_next = s + 4'd1;
    check("clr_count", count, 0);
    check("clr_valid", rd_valid, 0);
    check("clr_overflow", overflow, 0);
    check("clr_drop_count", drop_count, 0);
    check("clr_stamp_runs", stamp_now, s_next);
    drive(32'h77, 1'b1);
    drive(32'h77, 1'b0);
    drive(32'h77, 1'b0);
    check("clr_relog_count", count, 1);
    drain("clr_relog");

    // Stamp wrap and capture gating
    do_reset();
    capture_en = 1'b1;
    drive(32'h1, 1'b1);
    for (int i = 0; i < 14; i++) drive(32'h1, 1'b0);
    check("wrap_stamp_15", stamp_now, 4'hF);
    drive(32'h2, 1'b1);
    check("wrap_stamp_0", stamp_now, 4'h0);
    drive(32'h3, 1'b1);
    check("wrap_count", count, 3);
    drain("wrap");
    capture_en = 1'b0;
    out_value  = 32'h9;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("gate_count", count, 0);
      check("gate_valid", rd_valid, 0);
    end
    capture_en = 1'b1;
    drive(32'h9, 1'b1);
    drive(32'h9, 1'b0);
    drive(32'h9, 1'b0);
    check("gate_reenable_count", count, 1);
    drain("gate");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
